// File: rtl/top_status_regfile.sv
// -----------------------------------------------------------------------------
// top_status_regfile
//
// APB-lite register file with NumStatus STATUS registers at BaseAddr + 4*idx.
// Each register reflects one channel: an IDLE/BUSY job state machine, sticky
// DONE and OVERRUN flags (write-1-to-clear) and an 8-bit wrapping job counter.
//
// STATUS[i] layout:
//   [0]     STATE    RO   (1 = BUSY)
//   [1]     DONE     W1C  set when a BUSY channel sees done_i
//   [2]     OVERRUN  W1C  set when a BUSY channel sees start_i without done_i
//   [15:8]  COUNT    RO   completed jobs, wraps 255 -> 0
//   others  read 0
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   psel_i .. pstrb_i      APB request (select, enable, direction, address,
//                          write data, byte strobes)
//   pready_o, prdata_o,    APB response, registered; prdata_o/pslverr_o are
//   pslverr_o              0 whenever pready_o is 0
//   start_i, done_i        per-channel job start / job done pulses
//   state_o                per-channel state straight from the state flops
//   irq_o                  registered OR of all DONE flags
// -----------------------------------------------------------------------------
module top_status_regfile #(
  parameter int unsigned NumStatus = 2,
  parameter logic [63:0] BaseAddr  = 64'h0,
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic [31:0]          pwdata_i,
  input  logic [3:0]           pstrb_i,
  output logic                 pready_o,
  output logic [31:0]          prdata_o,
  output logic                 pslverr_o,
  input  logic [NumStatus-1:0] start_i,
  input  logic [NumStatus-1:0] done_i,
  output logic [NumStatus-1:0] state_o,
  output logic                 irq_o
);

  // Bus FSM states
  //   state      | meaning
  //   B_IDLE     | no transfer in flight; a setup phase here arms the access
  //   B_ACCESS1  | first ACCESS cycle (wait state); read data / error sampled
  //   B_ACCESS2  | second ACCESS cycle, pready_o=1; writes commit here
  //
  // Channel FSM states (one per channel)
  //   state      | meaning
  //   IDLE       | no job running
  //   BUSY       | job running, waiting for done_i
  typedef enum logic [1:0] {
    B_IDLE    = 2'd0,
    B_ACCESS1 = 2'd1,
    B_ACCESS2 = 2'd2
  } bus_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [AddrWidth-1:0] MapBytes = AddrWidth'(4 * NumStatus);

  bus_e                       r_bus;
  logic                       r_pready;
  logic [31:0]                r_prdata;
  logic                       r_pslverr;
  logic                       r_irq;

  logic [AddrWidth-1:0]       w_offset;
  logic [AddrWidth-1:0]       w_word;
  logic                       w_addr_err;
  logic [31:0]                w_rd_data;
  logic                       w_wr_commit;

  logic [NumStatus-1:0]       w_state_vec;
  logic [NumStatus-1:0]       w_done_vec;
  logic [NumStatus-1:0]       w_ovr_vec;
  logic [NumStatus-1:0][7:0]  w_count_vec;

  logic                       w_unused;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  // The subtraction wraps for addresses below BaseAddr, which lands them far
  // above MapBytes and so flags them as errors without a separate compare.
  assign w_offset   = paddr_i - BaseAddr[AddrWidth-1:0];
  assign w_word     = w_offset >> 2;
  assign w_addr_err = (w_offset >= MapBytes) || (w_offset[1:0] != 2'b00);

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < int'(NumStatus); i++) begin
      if (w_word == AddrWidth'(i)) begin
        w_rd_data = {16'h0, w_count_vec[i], 5'h0, w_ovr_vec[i], w_done_vec[i],
                     w_state_vec[i]};
      end
    end
  end

  // Only byte 0 carries W1C bits; a write with pstrb_i[0]=0 is accepted
  // silently. The commit also requires psel/penable to still be held so a
  // master that drops psel in the last cycle aborts cleanly.
  assign w_wr_commit = (r_bus == B_ACCESS2) && psel_i && penable_i && pwrite_i
                       && !w_addr_err && pstrb_i[0];

  // ---------------------------------------------------------------------------
  // Bus FSM with registered response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bus     <= B_IDLE;
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
      unique case (r_bus)
        B_IDLE: begin
          if (psel_i && !penable_i) r_bus <= B_ACCESS1;
        end
        B_ACCESS1: begin
          if (!psel_i) begin
            r_bus <= B_IDLE;
          end else if (penable_i) begin
            r_bus     <= B_ACCESS2;
            r_pready  <= 1'b1;
            r_pslverr <= w_addr_err;
            r_prdata  <= (!pwrite_i && !w_addr_err) ? w_rd_data : 32'h0;
          end
          // psel high with penable low: master re-issued a setup, stay armed
        end
        B_ACCESS2: begin
          r_bus <= B_IDLE;
        end
        default: begin
          r_bus <= B_IDLE;
        end
      endcase
    end
  end

  assign pready_o  = r_pready;
  assign prdata_o  = r_prdata;
  assign pslverr_o = r_pslverr;

  // ---------------------------------------------------------------------------
  // Per-channel state, flags and counter
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NumStatus; g++) begin : g_chan
    state_e     r_state;
    logic       r_done;
    logic       r_ovr;
    logic [7:0] r_count;

    logic       w_sel;
    logic       w_clr_done;
    logic       w_clr_ovr;
    logic       w_hw_done;
    logic       w_hw_ovr;

    assign w_sel      = w_wr_commit && (w_word == AddrWidth'(g));
    assign w_clr_done = w_sel && pwdata_i[1];
    assign w_clr_ovr  = w_sel && pwdata_i[2];

    // done_i is only meaningful while a job runs; start_i while BUSY is an
    // overrun unless it arrives together with done_i (back-to-back job).
    assign w_hw_done  = (r_state == BUSY) && done_i[g];
    assign w_hw_ovr   = (r_state == BUSY) && start_i[g] && !done_i[g];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state <= IDLE;
        r_done  <= 1'b0;
        r_ovr   <= 1'b0;
        r_count <= 8'h00;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (start_i[g]) r_state <= BUSY;
          end
          BUSY: begin
            if (done_i[g] && !start_i[g]) r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
        // Hardware set takes priority over a same-cycle software clear.
        r_done <= w_hw_done || (r_done && !w_clr_done);
        r_ovr  <= w_hw_ovr  || (r_ovr  && !w_clr_ovr);
        if (w_hw_done) r_count <= r_count + 8'd1;
      end
    end

    assign w_state_vec[g] = (r_state == BUSY);
    assign w_done_vec[g]  = r_done;
    assign w_ovr_vec[g]   = r_ovr;
    assign w_count_vec[g] = r_count;
  end

  assign state_o = w_state_vec;

  // ---------------------------------------------------------------------------
  // Interrupt
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |w_done_vec;
    end
  end

  assign irq_o = r_irq;

  // Write-data and strobe bits that carry no function in this map.
  assign w_unused = ^{pwdata_i[31:3], pwdata_i[0], pstrb_i[3:1]};

endmodule

// File: tb/tb_top_status_regfile.sv
module tb_top_status_regfile;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        psel_i, penable_i, pwrite_i;
  logic [31:0] paddr_i, pwdata_i;
  logic [3:0]  pstrb_i;
  logic        pready_o, pslverr_o, irq_o;
  logic [31:0] prdata_o;
  logic [1:0]  start_i, done_i, state_o;

  always #5 clk_i = ~clk_i;

  top_status_regfile #(
    .NumStatus(2),
    .BaseAddr (64'h0),
    .AddrWidth(32)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .psel_i   (psel_i),
    .penable_i(penable_i),
    .pwrite_i (pwrite_i),
    .paddr_i  (paddr_i),
    .pwdata_i (pwdata_i),
    .pstrb_i  (pstrb_i),
    .pready_o (pready_o),
    .prdata_o (prdata_o),
    .pslverr_o(pslverr_o),
    .start_i  (start_i),
    .done_i   (done_i),
    .state_o  (state_o),
    .irq_o    (irq_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: plain per-channel variables updated by job-level rules.
  bit m_busy [2];
  bit m_done [2];
  bit m_ovr  [2];
  int m_cnt  [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic bit addr_err(input logic [31:0] a);
    return (a >= 32'd8) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] reg_val(input int i);
    logic [7:0] c;
    c = 8'(m_cnt[i]);
    return {16'h0, c, 5'h0, m_ovr[i], m_done[i], m_busy[i]};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_ovr[i] = 0; m_cnt[i] = 0;
    end
  endfunction

  function automatic void model_pulse(input logic [1:0] s, input logic [1:0] d);
    for (int i = 0; i < 2; i++) begin
      if (!m_busy[i]) begin
        if (s[i]) m_busy[i] = 1;
      end else if (d[i]) begin
        m_done[i] = 1;
        m_cnt[i]  = (m_cnt[i] + 1) % 256;
        m_busy[i] = s[i];
      end else if (s[i]) begin
        m_ovr[i] = 1;
      end
    end
  endfunction

  task automatic chk_state_irq();
    chk("state_o", {30'b0, state_o}, {30'b0, m_busy[1], m_busy[0]});
    @(posedge clk_i); #1;
    chk("irq_o", {31'b0, irq_o}, {31'b0, m_done[0] | m_done[1]});
  endtask

  // Monitor: pops the scoreboard whenever a completed transfer is presented.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (pready_o && psel_i && penable_i) begin
        if (q_exp.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pready: got pready=1 expected no response at %0t", $time);
        end else begin
          exp_t e;
          e = q_exp.pop_front();
          chk("prdata", prdata_o, e.data);
          chk("pslverr", {31'b0, pslverr_o}, {31'b0, e.err});
        end
      end else if (!pready_o) begin
        chk("idle_prdata", prdata_o, 32'h0);
        chk("idle_pslverr", {31'b0, pslverr_o}, 32'h0);
      end
    end
  end

  task automatic pulse(input logic [1:0] s, input logic [1:0] d);
    @(posedge clk_i); #1;
    start_i = s; done_i = d;
    @(posedge clk_i); #1;
    start_i = '0; done_i = '0;
    model_pulse(s, d);
    chk_state_irq();
  endtask

  // Full APB transfer; ps/pd are pulsed during the second ACCESS cycle.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic [1:0] ps, input logic [1:0] pd);
    exp_t e;
    int   n;
    bit   err;
    err    = addr_err(a);
    e.err  = err;
    e.data = (w || err) ? 32'h0 : reg_val(int'(a[2]));
    q_exp.push_back(e);
    @(posedge clk_i); #1;
    psel_i = 1; penable_i = 0; paddr_i = a; pwrite_i = w; pwdata_i = d; pstrb_i = s;
    @(posedge clk_i); #1;
    penable_i = 1;
    @(negedge clk_i);
    n = 1;
    while (!pready_o && n < 8) begin
      @(posedge clk_i); #1;
      if (n == 1) begin start_i = ps; done_i = pd; end
      else begin start_i = '0; done_i = '0; end
      @(negedge clk_i);
      n++;
    end
    chk("pready_latency", 32'(n), 32'd2);
    @(posedge clk_i); #1;
    psel_i = 0; penable_i = 0; start_i = '0; done_i = '0;
    if (w && !err && s[0]) begin
      if (d[1]) m_done[a[2]] = 0;
      if (d[2]) m_ovr[a[2]]  = 0;
    end
    model_pulse(ps, pd);
    chk_state_irq();
  endtask

  task automatic rd(input logic [31:0] a);
    xfer(a, 1'b0, 32'h0, 4'h0, 2'b00, 2'b00);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    xfer(a, 1'b1, d, s, 2'b00, 2'b00);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_pready"}, {31'b0, pready_o}, 32'h0);
    chk({nm, "_prdata"}, prdata_o, 32'h0);
    chk({nm, "_pslverr"}, {31'b0, pslverr_o}, 32'h0);
    chk({nm, "_irq"}, {31'b0, irq_o}, 32'h0);
    chk({nm, "_state"}, {30'b0, state_o}, 32'h0);
  endtask

  logic [31:0] addr_pool [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 0; psel_i = 0; penable_i = 0; pwrite_i = 0;
    paddr_i = '0; pwdata_i = '0; pstrb_i = '0; start_i = '0; done_i = '0;
    model_reset();
    addr_pool[0] = 32'h0;  addr_pool[1] = 32'h4;  addr_pool[2] = 32'h8;
    addr_pool[3] = 32'h2;  addr_pool[4] = 32'h0;  addr_pool[5] = 32'h4;
    addr_pool[6] = 32'hC;  addr_pool[7] = 32'hFFFF_FFFC;

    #12;
    chk_outputs_zero("reset");
    @(negedge clk_i); rst_ni = 1;

    rd(32'h0);
    rd(32'h4);

    pulse(2'b01, 2'b00);
    pulse(2'b00, 2'b01);
    chk("status0_after_job", reg_val(0), 32'h0000_0102);
    rd(32'h0);

    wr(32'h0, 32'h2, 4'h1);
    pulse(2'b01, 2'b00);
    pulse(2'b00, 2'b01);
    wr(32'h0, 32'h2, 4'h0);
    rd(32'h0);

    pulse(2'b10, 2'b00);
    pulse(2'b10, 2'b00);
    rd(32'h4);
    pulse(2'b10, 2'b10);
    rd(32'h4);

    rd(32'h8);
    rd(32'h2);

    for (int j = 0; j < 256; j++) begin
      pulse(2'b01, 2'b00);
      pulse(2'b00, 2'b01);
    end
    rd(32'h0);

    // Hardware DONE set coinciding with a W1C of DONE
    pulse(2'b01, 2'b00);
    xfer(32'h0, 1'b1, 32'h2, 4'h1, 2'b00, 2'b01);
    rd(32'h0);

    // Write aborted by psel dropping after the first ACCESS cycle
    @(posedge clk_i); #1;
    psel_i = 1; penable_i = 0; paddr_i = 32'h0; pwrite_i = 1; pwdata_i = 32'h6; pstrb_i = 4'h1;
    @(posedge clk_i); #1;
    penable_i = 1;
    @(posedge clk_i); #1;
    psel_i = 0; penable_i = 0;
    @(posedge clk_i); #1;
    rd(32'h0);

    // Async reset in the middle of an ACCESS phase
    @(posedge clk_i); #1;
    psel_i = 1; penable_i = 0; paddr_i = 32'h4; pwrite_i = 0;
    @(posedge clk_i); #1;
    penable_i = 1;
    #2 rst_ni = 0;
    #1 chk_outputs_zero("mid_reset");
    psel_i = 0; penable_i = 0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i); rst_ni = 1;
    rd(32'h0);
    rd(32'h4);

    for (int k = 0; k < 200; k++) begin
      int          op;
      logic [1:0]  s, d;
      logic [31:0] a;
      op = $urandom_range(0, 3);
      s  = 2'($urandom_range(0, 3));
      d  = 2'($urandom_range(0, 3));
      a  = addr_pool[$urandom_range(0, 7)];
      case (op)
        0: pulse(s, d);
        1: rd(a);
        2: xfer(a, 1'b1, $urandom, 4'($urandom_range(0, 15)), 2'b00, 2'b00);
        default: xfer(a, 1'($urandom_range(0, 1)), $urandom & 32'h6, 4'h1, s, d);
      endcase
    end

    rd(32'h0);
    rd(32'h4);
    repeat (3) @(posedge clk_i);
    #1 chk("scoreboard_drained", 32'(q_exp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
